// File: rtl/spi_seq_pkg.sv
// Shared constants, payload types and FSM states for the SPI request sequencer.
// Register map of the SPI master core plus helpers to build its write data.
package spi_seq_pkg;

  localparam int unsigned REG_AW  = 2;
  localparam int unsigned SLAVE_W = 3;
  localparam int unsigned CFG_W   = 6;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned TIMER_W = 16;

  localparam logic [REG_AW-1:0] ADDR_CTRL = 2'd0;
  localparam logic [REG_AW-1:0] ADDR_DATA = 2'd1;
  localparam logic [REG_AW-1:0] ADDR_SS   = 2'd2;
  localparam logic [REG_AW-1:0] ADDR_CMD  = 2'd3;

  localparam int unsigned STAT_ENDTX = 0;
  localparam logic [BYTE_W-1:0] CMD_START = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_CLEAR = 8'h00;
  localparam logic [BYTE_W-1:0] SS_NONE   = 8'h00;

  localparam int unsigned CTRL_CPOL_BIT = 0;
  localparam int unsigned CTRL_CPHA_BIT = 1;
  localparam int unsigned CTRL_CPRE_LSB = 2;

  typedef struct packed {
    logic [3:0] cpre;
    logic       cpha;
    logic       cpol;
  } cfg_t;

  typedef struct packed {
    logic [SLAVE_W-1:0] slave;
    cfg_t               cfg;
    logic [BYTE_W-1:0]  tx;
  } req_payload_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CFG, ST_SEL, ST_LOAD, ST_START, ST_CLR,
    ST_WAIT_LO, ST_WAIT_HI, ST_RDRX, ST_DESEL, ST_DONE
  } seq_state_t;

  function automatic logic [BYTE_W-1:0] ctrl_word(input cfg_t c);
    logic [BYTE_W-1:0] w;
    w = '0;
    w[CTRL_CPOL_BIT]       = c.cpol;
    w[CTRL_CPHA_BIT]       = c.cpha;
    w[CTRL_CPRE_LSB +: 4]  = c.cpre;
    return w;
  endfunction

  function automatic logic [BYTE_W-1:0] ss_onehot(input logic [SLAVE_W-1:0] s);
    return BYTE_W'(1) << s;
  endfunction

endpackage

// File: rtl/spi_req_sequencer_if.sv
// Requester-side and SPI-master register-side signals of the sequencer.
interface spi_req_sequencer_if
  import spi_seq_pkg::*;
#(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]         Req;
  logic [NREQ*SLAVE_W-1:0] ReqSlave;
  logic [NREQ*CFG_W-1:0]   ReqCfg;
  logic [NREQ*BYTE_W-1:0]  ReqTx;
  logic [NREQ-1:0]         Ack;
  logic                    Err;
  logic [BYTE_W-1:0]       RxByte;
  logic                    Busy;
  logic [REG_AW-1:0]       RegAddr;
  logic                    RegWr;
  logic [BYTE_W-1:0]       RegDataWr;
  logic [BYTE_W-1:0]       RegDataRd;

  modport master (
    input  Req, ReqSlave, ReqCfg, ReqTx, RegDataRd,
    output Ack, Err, RxByte, Busy, RegAddr, RegWr, RegDataWr
  );

  modport slave (
    output Req, ReqSlave, ReqCfg, ReqTx, RegDataRd,
    input  Ack, Err, RxByte, Busy, RegAddr, RegWr, RegDataWr
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module spi_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      j = (int'(ptr) + i) % int'(NREQ);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spi_req_sequencer.sv
// Shares one SPI master among NREQ requesters: round-robin grant, fixed register
// program per transfer, watchdog abort on a stuck EndTx.
module spi_req_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TO_CYCLES = 4096
) (
  input  logic                 Clk,
  input  logic                 Rst,
  spi_req_sequencer_if.master  bus
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TO_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(NREQ - 1);

  seq_state_t          state;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    rr_ptr;
  req_payload_t        cur;
  cfg_t                last_cfg;
  logic                cfg_valid;
  logic [TIMER_W-1:0]  timer;
  logic                abort;
  logic [NREQ-1:0]     ack;
  logic                err;
  logic [BYTE_W-1:0]   rx_byte;
  logic                busy;
  logic [REG_AW-1:0]   reg_addr;
  logic                reg_wr;
  logic [BYTE_W-1:0]   reg_data_wr;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  req_payload_t        pick_pl;
  logic                cfg_reuse_c;

  spi_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (bus.Req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Payload of the requester the arbiter would grant this cycle.
  always_comb begin
    pick_pl.slave = bus.ReqSlave[SLAVE_W*pick_idx +: SLAVE_W];
    pick_pl.cfg   = cfg_t'(bus.ReqCfg[CFG_W*pick_idx +: CFG_W]);
    pick_pl.tx    = bus.ReqTx[BYTE_W*pick_idx +: BYTE_W];
    cfg_reuse_c   = cfg_valid && (pick_pl.cfg == last_cfg);
  end

  // Bus outputs are registered: each state's access is staged on the edge entering it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      cur         <= '0;
      last_cfg    <= '0;
      cfg_valid   <= 1'b0;
      timer       <= '0;
      abort       <= 1'b0;
      ack         <= '0;
      err         <= 1'b0;
      rx_byte     <= '0;
      busy        <= 1'b0;
      reg_addr    <= ADDR_CTRL;
      reg_wr      <= 1'b0;
      reg_data_wr <= '0;
    end else begin
      reg_wr <= 1'b0;
      ack    <= '0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= pick_idx;
            cur   <= pick_pl;
            busy  <= 1'b1;
            abort <= 1'b0;
            reg_wr <= 1'b1;
            if (cfg_reuse_c) begin
              state       <= ST_SEL;
              reg_addr    <= ADDR_SS;
              reg_data_wr <= ss_onehot(pick_pl.slave);
            end else begin
              state       <= ST_CFG;
              reg_addr    <= ADDR_CTRL;
              reg_data_wr <= ctrl_word(pick_pl.cfg);
              last_cfg    <= pick_pl.cfg;
              cfg_valid   <= 1'b1;
            end
          end
        end
        ST_CFG: begin
          state       <= ST_SEL;
          reg_wr      <= 1'b1;
          reg_addr    <= ADDR_SS;
          reg_data_wr <= ss_onehot(cur.slave);
        end
        ST_SEL: begin
          state       <= ST_LOAD;
          reg_wr      <= 1'b1;
          reg_addr    <= ADDR_DATA;
          reg_data_wr <= cur.tx;
        end
        ST_LOAD: begin
          state       <= ST_START;
          reg_wr      <= 1'b1;
          reg_addr    <= ADDR_CMD;
          reg_data_wr <= CMD_START;
        end
        ST_START: begin
          state       <= ST_CLR;
          reg_wr      <= 1'b1;
          reg_addr    <= ADDR_CMD;
          reg_data_wr <= CMD_CLEAR;
        end
        ST_CLR: begin
          state    <= ST_WAIT_LO;
          reg_addr <= ADDR_CMD;
          timer    <= '0;
        end
        ST_WAIT_LO: begin
          if (!bus.RegDataRd[STAT_ENDTX]) begin
            state <= ST_WAIT_HI;
            timer <= '0;
          end else if (timer == TO_LAST) begin
            abort       <= 1'b1;
            state       <= ST_DESEL;
            reg_wr      <= 1'b1;
            reg_addr    <= ADDR_SS;
            reg_data_wr <= SS_NONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (bus.RegDataRd[STAT_ENDTX]) begin
            state    <= ST_RDRX;
            reg_addr <= ADDR_DATA;
          end else if (timer == TO_LAST) begin
            abort       <= 1'b1;
            state       <= ST_DESEL;
            reg_wr      <= 1'b1;
            reg_addr    <= ADDR_SS;
            reg_data_wr <= SS_NONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RDRX: begin
          rx_byte     <= bus.RegDataRd;
          state       <= ST_DESEL;
          reg_wr      <= 1'b1;
          reg_addr    <= ADDR_SS;
          reg_data_wr <= SS_NONE;
        end
        ST_DESEL: begin
          state <= ST_DONE;
          ack   <= NREQ'(1) << grant;
          err   <= abort;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          rr_ptr <= (grant == IDX_MAX) ? '0 : grant + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Ack       = ack;
  assign bus.Err       = err;
  assign bus.RxByte    = rx_byte;
  assign bus.Busy      = busy;
  assign bus.RegAddr   = reg_addr;
  assign bus.RegWr     = reg_wr;
  assign bus.RegDataWr = reg_data_wr;

endmodule

// File: tb/tb_spi_req_sequencer.sv
// Directed bench: transaction-level model of arbitration and the register program,
// checked every cycle against the sequencer driving a small SPI master model.
module tb_spi_req_sequencer;
  import spi_seq_pkg::*;

  localparam int NREQ      = 4;
  localparam int TO_CYCLES = 16;
  localparam int LAT       = 4;

  typedef struct { logic [1:0] a; logic [7:0] d; } wr_t;
  typedef struct { int idx; logic err; logic [7:0] rx; } ack_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  spi_req_sequencer_if #(.NREQ(NREQ)) bus();
  spi_req_sequencer #(.NREQ(NREQ), .TO_CYCLES(TO_CYCLES)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  // SPI master register model: transfer ends LAT cycles after StartTx, echoing tx ^ 0x99.
  logic       endtx;
  logic [7:0] sm_tx, sm_rx;
  int         sm_cnt;
  logic       stuck = 1'b0;

  always @(posedge Clk) begin
    if (Rst) begin
      endtx <= 1'b1; sm_cnt <= 0; sm_tx <= 8'h00; sm_rx <= 8'h00;
    end else begin
      if (bus.RegWr && bus.RegAddr == ADDR_DATA) sm_tx <= bus.RegDataWr;
      if (bus.RegWr && bus.RegAddr == ADDR_CMD && bus.RegDataWr[0]) begin
        endtx <= 1'b0; sm_cnt <= stuck ? 0 : LAT;
      end else if (sm_cnt == 1) begin
        endtx <= 1'b1; sm_rx <= sm_tx ^ 8'h99; sm_cnt <= 0;
      end else if (sm_cnt > 1) begin
        sm_cnt <= sm_cnt - 1;
      end
    end
  end

  always_comb begin
    case (bus.RegAddr)
      ADDR_DATA: bus.RegDataRd = sm_rx;
      ADDR_CMD:  bus.RegDataRd = {7'b0, endtx};
      default:   bus.RegDataRd = 8'h00;
    endcase
  end

  int tests = 0, fails = 0, cyc = 0, acks_seen = 0;
  int cnt_left[NREQ];
  logic [2:0] r_slave[NREQ];
  logic [5:0] r_cfg[NREQ];
  logic [7:0] r_tx[NREQ];
  int m_rr = 0; bit m_cfg_valid = 0; logic [5:0] m_last_cfg = '0;
  logic [7:0] m_rx_pred = '0, m_rx_now = '0;
  wr_t exp_wr[$]; ack_t exp_ack[$];
  wr_t wlog[$]; int wcyc[$]; int ack_order[$];
  int last_idx; logic last_err; logic [7:0] last_rx;
  bit prev_ack = 0, drop_on_load = 0; int drop_idx = 0;
  logic [1:0] lit_a[6] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd2};
  logic [7:0] lit_d[6] = '{8'h05, 8'h08, 8'hA5, 8'h01, 8'h00, 8'h00};
  int lit_order[5] = '{0, 1, 2, 3, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"},   32'(bus.Ack), 32'h0);
    check({tag, "_err"},   32'(bus.Err), 32'h0);
    check({tag, "_rx"},    32'(bus.RxByte), 32'h0);
    check({tag, "_busy"},  32'(bus.Busy), 32'h0);
    check({tag, "_regwr"}, 32'(bus.RegWr), 32'h0);
    check({tag, "_addr"},  32'(bus.RegAddr), 32'h0);
    check({tag, "_wdata"}, 32'(bus.RegDataWr), 32'h0);
  endtask

  // Serve pending requests in round-robin order and queue the expected bus traffic.
  task automatic predict(input bit to_mode);
    int c[NREQ]; bit found; int j;
    for (int i = 0; i < NREQ; i++) c[i] = cnt_left[i];
    do begin
      found = 0; j = 0;
      for (int k = 0; k < NREQ; k++)
        if (!found && c[(m_rr + k) % NREQ] > 0) begin found = 1; j = (m_rr + k) % NREQ; end
      if (found) begin
        c[j]--;
        if (!(m_cfg_valid && m_last_cfg == r_cfg[j])) begin
          exp_wr.push_back('{ADDR_CTRL, {2'b00, r_cfg[j]}});
          m_last_cfg = r_cfg[j]; m_cfg_valid = 1;
        end
        exp_wr.push_back('{ADDR_SS, 8'd1 << r_slave[j]});
        exp_wr.push_back('{ADDR_DATA, r_tx[j]});
        exp_wr.push_back('{ADDR_CMD, 8'h01});
        exp_wr.push_back('{ADDR_CMD, 8'h00});
        exp_wr.push_back('{ADDR_SS, 8'h00});
        if (!to_mode) m_rx_pred = r_tx[j] ^ 8'h99;
        exp_ack.push_back('{j, to_mode, m_rx_pred});
        m_rr = (j + 1) % NREQ;
      end
    end while (found);
  endtask

  task automatic setup(input int i, input logic [2:0] s, input logic [5:0] cf, input logic [7:0] tx, input int n);
    r_slave[i] = s; r_cfg[i] = cf; r_tx[i] = tx; cnt_left[i] = n;
    bus.ReqSlave[i*3 +: 3] = s; bus.ReqCfg[i*6 +: 6] = cf; bus.ReqTx[i*8 +: 8] = tx;
  endtask

  task automatic raise();
    for (int i = 0; i < NREQ; i++) if (cnt_left[i] > 0) bus.Req[i] = 1'b1;
  endtask

  // One cycle: compare outputs against the model, then act as the requesters.
  task automatic tick();
    wr_t e; ack_t a; logic [NREQ-1:0] oh; int aidx;
    @(negedge Clk);
    cyc++;
    if (!Rst) begin
      if (bus.RegWr) begin
        tests++;
        if (exp_wr.size() == 0) begin
          fails++;
          $display("FAIL bus_write: got A%0d<-0x%02h, want no write", bus.RegAddr, bus.RegDataWr);
        end else begin
          e = exp_wr.pop_front();
          if (bus.RegAddr !== e.a || bus.RegDataWr !== e.d) begin
            fails++;
            $display("FAIL bus_write: got A%0d<-0x%02h, want A%0d<-0x%02h", bus.RegAddr, bus.RegDataWr, e.a, e.d);
          end
        end
        wlog.push_back('{bus.RegAddr, bus.RegDataWr}); wcyc.push_back(cyc);
      end
      if (bus.Ack != '0) begin
        aidx = -1;
        for (int i = 0; i < NREQ; i++) if (bus.Ack[i]) aidx = i;
        ack_order.push_back(aidx);
        last_idx = aidx; last_err = bus.Err; last_rx = bus.RxByte; acks_seen++;
        tests++;
        if (exp_ack.size() == 0) begin
          fails++;
          $display("FAIL ack: got Ack=%b, want no Ack", bus.Ack);
        end else begin
          a = exp_ack.pop_front();
          oh = '0; oh[a.idx] = 1'b1;
          m_rx_now = a.rx;
          if (bus.Ack !== oh || bus.Err !== a.err || bus.RxByte !== a.rx) begin
            fails++;
            $display("FAIL ack: got Ack=%b Err=%b Rx=0x%02h, want Ack=%b Err=%b Rx=0x%02h",
                     bus.Ack, bus.Err, bus.RxByte, oh, a.err, a.rx);
          end
        end
      end
      if (prev_ack) begin
        tests++;
        if (bus.Busy !== 1'b0 || bus.RegWr !== 1'b0) begin
          fails++;
          $display("FAIL post_ack: got Busy=%b RegWr=%b, want 0 0", bus.Busy, bus.RegWr);
        end
      end
      if (!bus.Busy) begin
        tests++;
        if (bus.RxByte !== m_rx_now) begin
          fails++;
          $display("FAIL rx_hold: got 0x%02h, want 0x%02h", bus.RxByte, m_rx_now);
        end
      end
      prev_ack = (bus.Ack != '0);
      for (int i = 0; i < NREQ; i++)
        if (bus.Ack[i] && cnt_left[i] > 0) begin
          cnt_left[i]--;
          if (cnt_left[i] == 0) bus.Req[i] = 1'b0;
        end
      if (drop_on_load && bus.RegWr && bus.RegAddr == ADDR_DATA) begin
        bus.Req[drop_idx] = 1'b0; drop_on_load = 0;
      end
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int start; int b;
    start = acks_seen; b = 0;
    while (acks_seen - start < n && b < budget) begin tick(); b++; end
    check("ack_arrival", 32'(acks_seen - start), 32'(n));
    tick(); tick();
    check("model_drained", 32'(exp_wr.size() + exp_ack.size()), 32'h0);
  endtask

  function automatic int ctrl_writes();
    int n = 0;
    foreach (wlog[i]) if (wlog[i].a == ADDR_CTRL) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c_clr, c_desel; bit seen;
    bus.Req = '0; bus.ReqSlave = '0; bus.ReqCfg = '0; bus.ReqTx = '0;
    for (int i = 0; i < NREQ; i++) cnt_left[i] = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_vals("reset");
    Rst = 1'b0;

    // Fairness: all four request, requester 0 twice.
    setup(0, 3'd0, 6'h06, 8'h10, 2); setup(1, 3'd1, 6'h06, 8'h21, 1);
    setup(2, 3'd2, 6'h0A, 8'h32, 1); setup(3, 3'd7, 6'h0F, 8'h43, 1);
    predict(0); raise();
    wait_acks(5, 1000);
    check("fair_count", 32'(ack_order.size()), 32'd5);
    foreach (lit_order[i]) if (i < ack_order.size()) check("fair_order", 32'(ack_order[i]), 32'(lit_order[i]));

    // Single request with the reference bus sequence.
    wlog.delete();
    setup(0, 3'd3, 6'h05, 8'hA5, 1); predict(0); raise();
    wait_acks(1, 200);
    check("single_nwr", 32'(wlog.size()), 32'd6);
    foreach (lit_a[i]) if (i < wlog.size()) begin
      check("single_wr_addr", 32'(wlog[i].a), 32'(lit_a[i]));
      check("single_wr_data", 32'(wlog[i].d), 32'(lit_d[i]));
    end
    check("single_ack_idx", 32'(last_idx), 32'd0);
    check("single_err", 32'(last_err), 32'd0);
    check("single_rx", 32'(last_rx), 32'h3C);

    // Same cfg: no CTRL write; changed cfg: CTRL rewritten.
    wlog.delete();
    setup(0, 3'd3, 6'h05, 8'h11, 1); predict(0); raise();
    wait_acks(1, 200);
    check("reuse_ctrl_n", 32'(ctrl_writes()), 32'd0);
    wlog.delete();
    setup(0, 3'd3, 6'h06, 8'h12, 1); predict(0); raise();
    wait_acks(1, 200);
    check("rewrite_ctrl_n", 32'(ctrl_writes()), 32'd1);
    if (wlog.size() > 0) check("rewrite_ctrl_data", 32'(wlog[0].d), 32'h06);

    // Requester 2 drops Req during LOAD; transfer still completes.
    setup(2, 3'd5, 6'h0F, 8'h5A, 1); drop_on_load = 1; drop_idx = 2;
    predict(0); raise();
    wait_acks(1, 200);
    check("drop_ack_idx", 32'(last_idx), 32'd2);
    check("drop_rx", 32'(last_rx), 32'hC3);

    // EndTx stuck low: abort after TO_CYCLES in WAIT_HI.
    wlog.delete(); wcyc.delete(); stuck = 1'b1;
    setup(1, 3'd0, 6'h06, 8'h77, 1); predict(1); raise();
    wait_acks(1, 200);
    c_clr = -1000; c_desel = 0;
    foreach (wlog[i]) begin
      if (wlog[i].a == ADDR_CMD && wlog[i].d == 8'h00) c_clr = wcyc[i];
      if (wlog[i].a == ADDR_SS && wlog[i].d == 8'h00) c_desel = wcyc[i];
    end
    check("timeout_latency", 32'(c_desel - c_clr), 32'd18);
    check("timeout_err", 32'(last_err), 32'd1);
    check("timeout_rx_kept", 32'(last_rx), 32'hC3);

    // Reset during WAIT_HI, then a fresh transfer must rewrite CTRL.
    setup(3, 3'd2, 6'h0A, 8'h3E, 1); predict(0); raise();
    seen = 0;
    for (int b = 0; b < 100 && !seen; b++) begin
      tick();
      if (bus.RegWr && bus.RegAddr == ADDR_CMD && bus.RegDataWr == 8'h00) seen = 1;
    end
    check("midreset_reach_clr", 32'(seen), 32'd1);
    repeat (4) tick();
    Rst = 1'b1; bus.Req = '0;
    for (int i = 0; i < NREQ; i++) cnt_left[i] = 0;
    exp_wr.delete(); exp_ack.delete();
    m_rr = 0; m_cfg_valid = 0; m_rx_pred = 8'h00; m_rx_now = 8'h00; prev_ack = 0;
    tick();
    check_reset_vals("midreset");
    Rst = 1'b0; stuck = 1'b0;
    wlog.delete();
    setup(3, 3'd2, 6'h0A, 8'h3E, 1); predict(0); raise();
    wait_acks(1, 200);
    if (wlog.size() > 0) begin
      check("post_reset_first_addr", 32'(wlog[0].a), 32'h0);
      check("post_reset_first_data", 32'(wlog[0].d), 32'h0A);
    end
    check("post_reset_rx", 32'(last_rx), 32'hA7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
